// File: rtl/id_stage_reg_elastic_if.sv
// ID->EXE handshake bundle: upstream (in) side, downstream (out) side.
// slave = the pipeline register, master = the ID/EXE neighbours.
interface id_stage_reg_elastic_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int CMD_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              WB_EN_IN;
  logic              MEM_R_EN_IN;
  logic              MEM_W_EN_IN;
  logic              B_IN;
  logic              S_IN;
  logic              imm_IN;
  logic [CMD_W-1:0]  EXE_CMD_IN;
  logic [DATA_W-1:0] PC_in;
  logic [DATA_W-1:0] Val_Rn_IN;
  logic [DATA_W-1:0] Val_Rm_IN;
  logic [11:0]       Shift_operand_IN;
  logic [23:0]       Signed_imm_24_IN;
  logic [REG_W-1:0]  Dest_IN;

  logic              out_valid;
  logic              out_ready;
  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic              B;
  logic              S;
  logic              imm;
  logic [CMD_W-1:0]  EXE_CMD;
  logic [DATA_W-1:0] PC;
  logic [DATA_W-1:0] Val_Rn;
  logic [DATA_W-1:0] Val_Rm;
  logic [11:0]       Shift_operand;
  logic [23:0]       Signed_imm_24;
  logic [REG_W-1:0]  Dest;

  modport slave (
    input  in_valid, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
    input  B_IN, S_IN, imm_IN, EXE_CMD_IN, PC_in,
    input  Val_Rn_IN, Val_Rm_IN, Shift_operand_IN,
    input  Signed_imm_24_IN, Dest_IN, out_ready,
    output in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN,
    output B, S, imm, EXE_CMD, PC, Val_Rn, Val_Rm,
    output Shift_operand, Signed_imm_24, Dest
  );

  modport master (
    output in_valid, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
    output B_IN, S_IN, imm_IN, EXE_CMD_IN, PC_in,
    output Val_Rn_IN, Val_Rm_IN, Shift_operand_IN,
    output Signed_imm_24_IN, Dest_IN, out_ready,
    input  in_ready, out_valid, WB_EN, MEM_R_EN, MEM_W_EN,
    input  B, S, imm, EXE_CMD, PC, Val_Rn, Val_Rm,
    input  Shift_operand, Signed_imm_24, Dest
  );
endinterface

// File: rtl/id_stage_reg_elastic.sv
// Elastic ID->EXE register: valid/ready, optional 2-entry skid,
// flush, bubble gating of control enables and a saturating stall counter.
module id_stage_reg_elastic #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 4,
  parameter int CMD_W   = 4,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_stage_reg_elastic_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int BW = 6 + CMD_W + 3*DATA_W + 12 + 24 + REG_W;

  logic [BW-1:0]    in_b;
  logic [BW-1:0]    m_q, m_d;
  logic             m_vld_q, m_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_rdy;
  logic             acc;
  logic             dlv;

  assign in_b = {bus.WB_EN_IN, bus.MEM_R_EN_IN,
                 bus.MEM_W_EN_IN, bus.B_IN, bus.S_IN,
                 bus.imm_IN, bus.EXE_CMD_IN, bus.PC_in,
                 bus.Val_Rn_IN, bus.Val_Rm_IN,
                 bus.Shift_operand_IN,
                 bus.Signed_imm_24_IN, bus.Dest_IN};

  assign acc = bus.in_valid & in_rdy;
  assign dlv = m_vld_q & bus.out_ready;
  assign bus.in_ready = in_rdy;

  if (SKID_EN) begin : g_skid
    logic [BW-1:0] k_q, k_d;
    logic          k_vld_q, k_vld_d;

    // Ready depends only on skid occupancy, so it is a pure flop output.
    assign in_rdy = !k_vld_q;

    always_comb begin
      m_d     = m_q;
      m_vld_d = m_vld_q;
      k_d     = k_q;
      k_vld_d = k_vld_q;
      if (flush) begin
        m_vld_d = 1'b0;
        k_vld_d = 1'b0;
      end else if (acc && (!m_vld_q || dlv)) begin
        m_vld_d = 1'b1;
        if (k_vld_q) begin
          m_d = k_q;
          k_d = in_b;
        end else begin
          m_d = in_b;
        end
      end else if (acc) begin
        k_d     = in_b;
        k_vld_d = 1'b1;
      end else if (dlv) begin
        if (k_vld_q) begin
          m_d     = k_q;
          k_vld_d = 1'b0;
        end else begin
          m_vld_d = 1'b0;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        k_q     <= '0;
        k_vld_q <= 1'b0;
      end else begin
        k_q     <= k_d;
        k_vld_q <= k_vld_d;
      end
    end
  end else begin : g_single
    assign in_rdy = bus.out_ready | !m_vld_q;

    always_comb begin
      m_d     = m_q;
      m_vld_d = m_vld_q;
      if (flush) begin
        m_vld_d = 1'b0;
      end else if (acc) begin
        m_d     = in_b;
        m_vld_d = 1'b1;
      end else if (dlv) begin
        m_vld_d = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (m_vld_q && !bus.out_ready && cnt_q != '1)
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q     <= '0;
      m_vld_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      m_q     <= m_d;
      m_vld_q <= m_vld_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control enables are forced low in bubbles; data fields just hold.
  assign bus.out_valid = m_vld_q;
  assign bus.WB_EN     = m_q[BW-1] & m_vld_q;
  assign bus.MEM_R_EN  = m_q[BW-2] & m_vld_q;
  assign bus.MEM_W_EN  = m_q[BW-3] & m_vld_q;
  assign bus.B         = m_q[BW-4] & m_vld_q;
  assign bus.S         = m_q[BW-5] & m_vld_q;
  assign {bus.imm, bus.EXE_CMD, bus.PC, bus.Val_Rn,
          bus.Val_Rm, bus.Shift_operand,
          bus.Signed_imm_24, bus.Dest} = m_q[BW-6:0];
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_stage_reg_elastic.sv
// Scoreboard bench for id_stage_reg_elastic: skid and
// single-register instances driven with directed vectors.
module tb_id_stage_reg_elastic;
  typedef struct packed {
    logic        wb, mr, mw, b, s, imm;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [3:0]  dst;
  } bnd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic iv1 = 1'b0, ordy1 = 1'b0;
  logic iv0 = 1'b0, ordy0 = 1'b0;
  bnd_t in1 = '0, in0 = '0;
  bnd_t out1, out0;
  logic [3:0]  st1;
  logic [15:0] st0;
  bnd_t q1[$], q0[$];
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  id_stage_reg_elastic_if #(.DATA_W(32), .REG_W(4), .CMD_W(4)) bus1();
  id_stage_reg_elastic_if #(.DATA_W(32), .REG_W(4), .CMD_W(4)) bus0();

  id_stage_reg_elastic #(.DATA_W(32), .REG_W(4), .CMD_W(4),
    .SKID_EN(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .bus(bus1), .stall_cnt(st1));

  id_stage_reg_elastic #(.DATA_W(32), .REG_W(4), .CMD_W(4),
    .SKID_EN(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .bus(bus0), .stall_cnt(st0));

  assign bus1.in_valid  = iv1;
  assign bus1.out_ready = ordy1;
  assign {bus1.WB_EN_IN, bus1.MEM_R_EN_IN, bus1.MEM_W_EN_IN,
          bus1.B_IN, bus1.S_IN, bus1.imm_IN, bus1.EXE_CMD_IN,
          bus1.PC_in, bus1.Val_Rn_IN, bus1.Val_Rm_IN,
          bus1.Shift_operand_IN, bus1.Signed_imm_24_IN,
          bus1.Dest_IN} = in1;
  assign out1 = {bus1.WB_EN, bus1.MEM_R_EN, bus1.MEM_W_EN,
                 bus1.B, bus1.S, bus1.imm, bus1.EXE_CMD, bus1.PC,
                 bus1.Val_Rn, bus1.Val_Rm, bus1.Shift_operand,
                 bus1.Signed_imm_24, bus1.Dest};

  assign bus0.in_valid  = iv0;
  assign bus0.out_ready = ordy0;
  assign {bus0.WB_EN_IN, bus0.MEM_R_EN_IN, bus0.MEM_W_EN_IN,
          bus0.B_IN, bus0.S_IN, bus0.imm_IN, bus0.EXE_CMD_IN,
          bus0.PC_in, bus0.Val_Rn_IN, bus0.Val_Rm_IN,
          bus0.Shift_operand_IN, bus0.Signed_imm_24_IN,
          bus0.Dest_IN} = in0;
  assign out0 = {bus0.WB_EN, bus0.MEM_R_EN, bus0.MEM_W_EN,
                 bus0.B, bus0.S, bus0.imm, bus0.EXE_CMD, bus0.PC,
                 bus0.Val_Rn, bus0.Val_Rm, bus0.Shift_operand,
                 bus0.Signed_imm_24, bus0.Dest};

  function automatic bnd_t mk(logic [31:0] pc, logic wb);
    bnd_t x;
    x.wb  = wb;
    x.mr  = pc[2];
    x.mw  = ~pc[2];
    x.b   = pc[4];
    x.s   = pc[5] | wb;
    x.imm = pc[3];
    x.cmd = pc[5:2];
    x.pc  = pc;
    x.rn  = pc ^ 32'hA5A5_0000;
    x.rm  = ~pc;
    x.sh  = pc[11:0] ^ 12'h5A5;
    x.si  = pc[23:0] + 24'h10_0000;
    x.dst = ~pc[5:2];
    return x;
  endfunction

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitors: pop and compare on every delivery; flush drops held entries.
  always @(negedge clk) begin
    if (!rst && bus1.out_valid && ordy1) begin
      nvec++;
      if (q1.size() == 0) begin
        nerr++;
        $display("FAIL skid_unexpected: got pc %0h expected none",
                 out1.pc);
      end else begin
        bnd_t e;
        e = q1.pop_front();
        if (out1 !== e) begin
          nerr++;
          $display("FAIL skid_bundle: got %h expected %h", out1, e);
        end
      end
    end
    if (flush) q1.delete();
  end

  always @(negedge clk) begin
    if (!rst && bus0.out_valid && ordy0) begin
      nvec++;
      if (q0.size() == 0) begin
        nerr++;
        $display("FAIL single_unexpected: got pc %0h expected none",
                 out0.pc);
      end else begin
        bnd_t e;
        e = q0.pop_front();
        if (out0 !== e) begin
          nerr++;
          $display("FAIL single_bundle: got %h expected %h", out0, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ordy0 = 1'b1;
    cyc();
    chk("rst_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("rst_pc", out1.pc, 32'd0);
    chk("rst_ctl", 32'({out1.wb, out1.mr, out1.mw, out1.b, out1.s}), 32'd0);
    chk("rst_stall", 32'(st1), 32'd0);
    chk("rst_single_rdy", 32'(bus0.in_ready), 32'd1);
    rst = 1'b0;

    // single transfer then bubble
    cyc();
    iv1 = 1'b1; ordy1 = 1'b1; in1 = mk(32'h10, 1'b1); q1.push_back(in1);
    cyc();
    iv1 = 1'b0;
    @(negedge clk);
    chk("one_valid", 32'(bus1.out_valid), 32'd1);
    chk("one_pc", out1.pc, 32'h10);
    chk("one_wb", 32'(bus1.WB_EN), 32'd1);
    cyc();
    @(negedge clk);
    chk("bub_valid", 32'(bus1.out_valid), 32'd0);
    chk("bub_wb", 32'(bus1.WB_EN), 32'd0);

    // streaming
    cyc();
    for (int i = 0; i < 8; i++) begin
      iv1 = 1'b1; in1 = mk(32'(i*4), 1'(i)); q1.push_back(in1);
      @(negedge clk);
      chk("str_in_ready", 32'(bus1.in_ready), 32'd1);
      if (i > 0) chk("str_pc", out1.pc, 32'((i-1)*4));
      cyc();
    end
    iv1 = 1'b0;
    @(negedge clk);
    chk("str_last_pc", out1.pc, 32'h1C);
    cyc();
    @(negedge clk);
    chk("str_stall", 32'(st1), 32'd0);

    // backpressure fill
    cyc();
    ordy1 = 1'b0; iv1 = 1'b1; in1 = mk(32'h20, 1'b1); q1.push_back(in1);
    @(negedge clk); chk("bp_rdy0", 32'(bus1.in_ready), 32'd1);
    cyc();
    in1 = mk(32'h24, 1'b0); q1.push_back(in1);
    @(negedge clk); chk("bp_rdy1", 32'(bus1.in_ready), 32'd1);
    cyc();
    in1 = mk(32'h28, 1'b1);
    @(negedge clk);
    chk("bp_full_rdy", 32'(bus1.in_ready), 32'd0);
    chk("bp_hold_pc", out1.pc, 32'h20);
    cyc();
    @(negedge clk);
    chk("bp_rdy3", 32'(bus1.in_ready), 32'd0);
    chk("bp_stall2", 32'(st1), 32'd2);
    cyc();
    ordy1 = 1'b1;
    @(negedge clk); chk("bp_rdy_reg", 32'(bus1.in_ready), 32'd0);
    cyc();
    q1.push_back(in1);
    @(negedge clk); chk("bp_rdy_back", 32'(bus1.in_ready), 32'd1);
    cyc();
    iv1 = 1'b0;
    @(negedge clk); chk("bp_pc28", out1.pc, 32'h28);
    cyc();
    @(negedge clk);
    chk("bp_stall3", 32'(st1), 32'd3);
    chk("bp_drained", 32'(q1.size()), 32'd0);

    // flush with skid full
    cyc();
    ordy1 = 1'b0; iv1 = 1'b1; in1 = mk(32'h30, 1'b0); q1.push_back(in1);
    cyc();
    in1 = mk(32'h34, 1'b0); q1.push_back(in1);
    cyc();
    in1 = mk(32'h38, 1'b1); flush = 1'b1;
    @(negedge clk); chk("fl_rdy_full", 32'(bus1.in_ready), 32'd0);
    cyc();
    flush = 1'b0; iv1 = 1'b0; ordy1 = 1'b1;
    @(negedge clk);
    chk("fl_valid", 32'(bus1.out_valid), 32'd0);
    chk("fl_rdy", 32'(bus1.in_ready), 32'd1);
    chk("fl_b", 32'(bus1.B), 32'd0);
    chk("fl_mw", 32'(bus1.MEM_W_EN), 32'd0);
    cyc();
    iv1 = 1'b1; in1 = mk(32'h3C, 1'b1); flush = 1'b1;
    cyc();
    flush = 1'b0; iv1 = 1'b0;
    @(negedge clk);
    chk("fl_drop_valid", 32'(bus1.out_valid), 32'd0);
    chk("fl_keep_stall", 32'(st1), 32'd5);
    repeat (3) cyc();

    // saturation, then reset with skid full
    ordy1 = 1'b0; iv1 = 1'b1; in1 = mk(32'h40, 1'b1); q1.push_back(in1);
    cyc();
    in1 = mk(32'h44, 1'b0); q1.push_back(in1);
    cyc();
    iv1 = 1'b0;
    repeat (19) cyc();
    @(negedge clk);
    chk("sat_15", 32'(st1), 32'd15);
    repeat (3) cyc();
    @(negedge clk);
    chk("sat_hold", 32'(st1), 32'd15);
    chk("sat_pc", out1.pc, 32'h40);
    chk("sat_valid", 32'(bus1.out_valid), 32'd1);
    #2 rst = 1'b1;
    q1.delete(); q0.delete();
    #1;
    chk("arst_valid", 32'(bus1.out_valid), 32'd0);
    chk("arst_rdy", 32'(bus1.in_ready), 32'd1);
    chk("arst_stall", 32'(st1), 32'd0);
    chk("arst_pc", out1.pc, 32'd0);
    cyc();
    rst = 1'b0;

    // single-register mode
    cyc();
    iv0 = 1'b1; ordy0 = 1'b0; in0 = mk(32'h50, 1'b1); q0.push_back(in0);
    @(negedge clk); chk("sg_rdy0", 32'(bus0.in_ready), 32'd1);
    cyc();
    in0 = mk(32'h54, 1'b0);
    @(negedge clk); chk("sg_rdy_stall", 32'(bus0.in_ready), 32'd0);
    cyc();
    ordy0 = 1'b1; q0.push_back(in0);
    @(negedge clk); chk("sg_rdy_comb", 32'(bus0.in_ready), 32'd1);
    cyc();
    iv0 = 1'b0;
    @(negedge clk);
    chk("sg_nobubble", 32'(bus0.out_valid), 32'd1);
    chk("sg_pc54", out0.pc, 32'h54);
    cyc();
    @(negedge clk);
    chk("sg_empty", 32'(bus0.out_valid), 32'd0);
    chk("sg_wb", 32'(bus0.WB_EN), 32'd0);
    chk("sg_stall", 32'(st0), 32'd1);
    chk("sg_drained", 32'(q0.size()), 32'd0);
    chk("sk_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
